// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_DEC  = 4'd1,
    S_LD   = 4'd2,
    S_LDWB = 4'd3,
    S_ST   = 4'd4,
    S_ALU  = 4'd5,
    S_AWB  = 4'd6,
    S_JMP  = 4'd7,
    S_BZ   = 4'd8,
    S_HALT = 4'd9,
    S_ERR  = 4'd10
  } state_e;

  // Non-ALU opcodes (MSB clear); zero-extended for wider opcode fields.
  localparam logic [3:0] OP_LDI  = 4'd0;
  localparam logic [3:0] OP_STI  = 4'd1;
  localparam logic [3:0] OP_JMP  = 4'd2;
  localparam logic [3:0] OP_BZ   = 4'd3;
  localparam logic [3:0] OP_HALT = 4'd4;

  // Register file write-source select.
  localparam logic [1:0] RF_WSRC_ALU  = 2'd0;
  localparam logic [1:0] RF_WSRC_DI   = 2'd1;
  localparam logic [1:0] RF_WSRC_REG1 = 2'd2;

  // States that issue a memory access and therefore wait on mem_ready.
  function automatic logic is_mem_state(state_e s);
    return (s == S_IF) || (s == S_LD) || (s == S_ST);
  endfunction

endpackage

// File: rtl/mc_wait_watchdog.sv
// Counts consecutive not-ready cycles of a memory access; flags the last allowed one.
// Latency: expired is a combinational decode of the registered count.
// Backpressure: none; clr has priority over inc, count saturates at WAIT_MAX-1.
//
// Ports: clk, rst (async active-low), clr (restart count), inc (one more wait
// cycle), expired (count sits at WAIT_MAX-1; never set when WAIT_MAX == 0).
module mc_wait_watchdog #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  // Count only needs to reach WAIT_MAX-1.
  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CW-1:0] LIMIT = CW'((WAIT_MAX == 0) ? 0 : (WAIT_MAX - 1));

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr) begin
      wait_cnt_d = '0;
    end else if (inc && (wait_cnt_q != LIMIT)) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign expired = (WAIT_MAX != 0) && (wait_cnt_q == LIMIT);

endmodule

// File: rtl/mc_controller_p.sv
// Multicycle control FSM: fetch/decode/execute with memory wait watchdog and retire counter.
// Latency: outputs are decoded from the present state; next state on the following edge.
// Backpressure: memory states hold until mem_ready; WAIT_MAX consecutive misses -> ERR.
//
// Ports: clk, rst (async active-low); instr/zero/mem_ready/resume from IR, flags,
// memory and operator; datapath controls pc_ld, pc_src_jump, ir_ld, di_ld,
// rf_we, rf_wsrc, mem_addr_ir, mem_rd, mem_wr, alu_op, czn_ld; status halted,
// err (sticky), instr_cnt (retired instructions, wrapping).
module mc_controller_p
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] instr,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                pc_ld,
  output logic                pc_src_jump,
  output logic                ir_ld,
  output logic                di_ld,
  output logic                rf_we,
  output logic [1:0]          rf_wsrc,
  output logic                mem_addr_ir,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                czn_ld,
  output logic                halted,
  output logic                err,
  output logic [CNT_W-1:0]    instr_cnt
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
  logic              retire;
  logic              wd_expired;
  logic              wd_clr;
  logic              wd_inc;

  // Next-state logic. In memory states mem_ready is tested before the
  // watchdog so a completion on the last allowed cycle is still accepted.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IF: begin
        if (mem_ready)       state_d = S_DEC;
        else if (wd_expired) state_d = S_ERR;
      end
      S_DEC: begin
        if (instr[OPCODE_W-1])                   state_d = S_ALU;
        else if (instr == OPCODE_W'(OP_LDI))     state_d = S_LD;
        else if (instr == OPCODE_W'(OP_STI))     state_d = S_ST;
        else if (instr == OPCODE_W'(OP_JMP))     state_d = S_JMP;
        else if (instr == OPCODE_W'(OP_BZ))      state_d = S_BZ;
        else if (instr == OPCODE_W'(OP_HALT))    state_d = S_HALT;
        else begin
          // Remaining non-ALU codes are NOPs.
          state_d = S_IF;
          retire  = 1'b1;
        end
      end
      S_LD: begin
        if (mem_ready)       state_d = S_LDWB;
        else if (wd_expired) state_d = S_ERR;
      end
      S_ST: begin
        if (mem_ready) begin
          state_d = S_IF;
          retire  = 1'b1;
        end else if (wd_expired) begin
          state_d = S_ERR;
        end
      end
      S_ALU:  state_d = S_AWB;
      S_LDWB, S_AWB, S_JMP, S_BZ: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_HALT: begin
        if (resume) state_d = S_IF;
      end
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IF;
    endcase
  end

  // Any state change restarts the wait count, so each memory state starts fresh.
  assign wd_clr = (state_d != state_q);
  assign wd_inc = is_mem_state(state_q) && !mem_ready;

  mc_wait_watchdog #(
    .WAIT_MAX (WAIT_MAX)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  assign instr_cnt_d = instr_cnt_q + CNT_W'(retire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IF;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;

  // Output decode. Gated by rst so every control drops the moment reset
  // asserts, even though the reset state (IF) would otherwise request a read.
  always_comb begin
    pc_ld       = 1'b0;
    pc_src_jump = 1'b0;
    ir_ld       = 1'b0;
    di_ld       = 1'b0;
    rf_we       = 1'b0;
    rf_wsrc     = RF_WSRC_ALU;
    mem_addr_ir = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    alu_op      = '0;
    czn_ld      = 1'b0;
    halted      = 1'b0;
    err         = 1'b0;
    if (rst) begin
      case (state_q)
        S_IF: begin
          mem_rd = 1'b1;
          ir_ld  = mem_ready;
          pc_ld  = mem_ready;
        end
        S_LD: begin
          mem_rd      = 1'b1;
          mem_addr_ir = 1'b1;
          di_ld       = mem_ready;
        end
        S_LDWB: begin
          rf_we   = 1'b1;
          rf_wsrc = RF_WSRC_DI;
        end
        S_ST: begin
          mem_wr      = 1'b1;
          mem_addr_ir = 1'b1;
        end
        S_ALU: begin
          alu_op = instr[ALU_OP_W-1:0];
        end
        S_AWB: begin
          alu_op  = instr[ALU_OP_W-1:0];
          rf_we   = 1'b1;
          rf_wsrc = RF_WSRC_ALU;
          czn_ld  = 1'b1;
        end
        S_JMP: begin
          pc_ld       = 1'b1;
          pc_src_jump = 1'b1;
        end
        S_BZ: begin
          pc_ld       = zero;
          pc_src_jump = 1'b1;
        end
        S_HALT: halted = 1'b1;
        S_ERR:  err    = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller_p.sv
// Testbench for mc_controller_p: vector table, directed corner sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mc_controller_p;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] instr = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       resume = 1'b0;
  logic       pc_ld, pc_src_jump, ir_ld, di_ld, rf_we;
  logic [1:0] rf_wsrc;
  logic       mem_addr_ir, mem_rd, mem_wr;
  logic [2:0] alu_op;
  logic       czn_ld, halted, err;
  logic [1:0] instr_cnt;

  always #5 clk = ~clk;

  mc_controller_p #(
    .OPCODE_W (4),
    .ALU_OP_W (3),
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .resume      (resume),
    .pc_ld       (pc_ld),
    .pc_src_jump (pc_src_jump),
    .ir_ld       (ir_ld),
    .di_ld       (di_ld),
    .rf_we       (rf_we),
    .rf_wsrc     (rf_wsrc),
    .mem_addr_ir (mem_addr_ir),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .alu_op      (alu_op),
    .czn_ld      (czn_ld),
    .halted      (halted),
    .err         (err),
    .instr_cnt   (instr_cnt)
  );

  typedef struct packed {
    logic       pc_ld;
    logic       pc_src_jump;
    logic       ir_ld;
    logic       di_ld;
    logic       rf_we;
    logic [1:0] rf_wsrc;
    logic       mem_addr_ir;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] alu_op;
    logic       czn_ld;
    logic       halted;
    logic       err;
  } outs_t;

  typedef struct {
    logic [3:0] instr;
    logic       zero;
    logic       ready;
    logic       resume;
    outs_t      exp;
    logic [1:0] cnt;
  } vec_t;

  int errors = 0;
  int checks = 0;

  outs_t o_none, o_fetch, o_wait_if, o_ld, o_ldwb, o_alu5, o_awb5;
  outs_t o_bz0, o_jump, o_st, o_halt, o_err;
  vec_t  vecs[24];

  function automatic outs_t mk(input bit p, input bit j, input bit irl, input bit dil,
                               input bit we, input bit [1:0] ws, input bit a,
                               input bit rd, input bit wr, input bit [2:0] op,
                               input bit cz, input bit h, input bit e);
    outs_t o;
    o = {p, j, irl, dil, we, ws, a, rd, wr, op, cz, h, e};
    return o;
  endfunction

  function automatic vec_t mkv(input logic [3:0] i, input logic z, input logic r,
                               input logic res, input outs_t e, input logic [1:0] c);
    vec_t v;
    v.instr = i; v.zero = z; v.ready = r; v.resume = res; v.exp = e; v.cnt = c;
    return v;
  endfunction

  function automatic outs_t got_outs();
    outs_t o;
    o = {pc_ld, pc_src_jump, ir_ld, di_ld, rf_we, rf_wsrc, mem_addr_ir,
         mem_rd, mem_wr, alu_op, czn_ld, halted, err};
    return o;
  endfunction

  task automatic check_outs(input string name, input outs_t exp);
    outs_t g;
    g = got_outs();
    checks++;
    if (g !== exp) begin
      errors++;
      $display("FAIL %s @%0t: outputs got %h required %h", name, $time, g, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [1:0] exp);
    checks++;
    if (instr_cnt !== exp) begin
      errors++;
      $display("FAIL %s @%0t: instr_cnt got %0d required %0d", name, $time, instr_cnt, exp);
    end
  endtask

  task automatic drive(input logic [3:0] i, input logic z, input logic r, input logic res);
    instr = i; zero = z; mem_ready = r; resume = res;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // ---------------- Reference model (instruction-step view) ----------------
  localparam int CL_LD = 0, CL_ST = 1, CL_JMP = 2, CL_BZ = 3, CL_HALT = 4,
                 CL_NOP = 5, CL_ALU = 6;

  int       m_step;    // 0 fetch, 1 decode, 2.. execution steps of the class
  int       m_cls;
  int       m_waits;   // consecutive not-ready cycles in the current access
  bit       m_err;
  int       m_retired;
  bit [2:0] m_op;

  task automatic model_reset();
    m_step = 0; m_cls = CL_NOP; m_waits = 0; m_err = 0; m_retired = 0; m_op = '0;
  endtask

  function automatic outs_t model_out(input logic r, input logic z);
    outs_t o;
    o = '0;
    if (m_err) begin
      o.err = 1'b1;
      return o;
    end
    if (m_step == 0) begin
      o.mem_rd = 1'b1; o.ir_ld = r; o.pc_ld = r;
    end else if (m_step == 2) begin
      case (m_cls)
        CL_LD:   begin o.mem_rd = 1'b1; o.mem_addr_ir = 1'b1; o.di_ld = r; end
        CL_ST:   begin o.mem_wr = 1'b1; o.mem_addr_ir = 1'b1; end
        CL_ALU:  o.alu_op = m_op;
        CL_JMP:  begin o.pc_ld = 1'b1; o.pc_src_jump = 1'b1; end
        CL_BZ:   begin o.pc_ld = z; o.pc_src_jump = 1'b1; end
        CL_HALT: o.halted = 1'b1;
        default: ;
      endcase
    end else if (m_step == 3) begin
      if (m_cls == CL_LD) begin
        o.rf_we = 1'b1; o.rf_wsrc = 2'd1;
      end else begin
        o.alu_op = m_op; o.rf_we = 1'b1; o.czn_ld = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic model_step(input logic [3:0] i, input logic r, input logic res);
    int nstep;
    bit ret;
    bit waiting;
    if (m_err) return;
    nstep = m_step; ret = 0; waiting = 0;
    case (m_step)
      0: if (r) nstep = 1; else waiting = 1;
      1: begin
        m_cls = i[3] ? CL_ALU : ((i < 4'd5) ? int'(i) : CL_NOP);
        m_op  = i[2:0];
        if (m_cls == CL_NOP) begin ret = 1; nstep = 0; end
        else nstep = 2;
      end
      2: begin
        case (m_cls)
          CL_LD:   if (r) nstep = 3; else waiting = 1;
          CL_ST:   if (r) begin ret = 1; nstep = 0; end else waiting = 1;
          CL_ALU:  nstep = 3;
          CL_HALT: if (res) nstep = 0;
          default: begin ret = 1; nstep = 0; end
        endcase
      end
      default: begin ret = 1; nstep = 0; end
    endcase
    if (waiting) begin
      m_waits++;
      if (WAIT_MAX != 0 && m_waits >= WAIT_MAX) m_err = 1;
    end
    if (nstep != m_step) m_waits = 0;
    if (ret) m_retired++;
    m_step = nstep;
  endtask

  initial begin
    logic [3:0] cur_instr;
    logic       r, z, res;
    int         err_cycles;

    o_none    = '0;
    o_fetch   = mk(1,0,1,0,0,2'd0,0,1,0,3'd0,0,0,0);
    o_wait_if = mk(0,0,0,0,0,2'd0,0,1,0,3'd0,0,0,0);
    o_ld      = mk(0,0,0,1,0,2'd0,1,1,0,3'd0,0,0,0);
    o_ldwb    = mk(0,0,0,0,1,2'd1,0,0,0,3'd0,0,0,0);
    o_alu5    = mk(0,0,0,0,0,2'd0,0,0,0,3'd5,0,0,0);
    o_awb5    = mk(0,0,0,0,1,2'd0,0,0,0,3'd5,1,0,0);
    o_bz0     = mk(0,1,0,0,0,2'd0,0,0,0,3'd0,0,0,0);
    o_jump    = mk(1,1,0,0,0,2'd0,0,0,0,3'd0,0,0,0);
    o_st      = mk(0,0,0,0,0,2'd0,1,0,1,3'd0,0,0,0);
    o_halt    = mk(0,0,0,0,0,2'd0,0,0,0,3'd0,0,1,0);
    o_err     = mk(0,0,0,0,0,2'd0,0,0,0,3'd0,0,0,1);

    //              instr  z     rdy   res   expected  cnt
    vecs[0]  = mkv(4'h0, 1'b0, 1'b1, 1'b0, o_fetch,   2'd0); // LD fetch
    vecs[1]  = mkv(4'h0, 1'b0, 1'b1, 1'b0, o_none,    2'd0); // DEC
    vecs[2]  = mkv(4'h0, 1'b0, 1'b1, 1'b0, o_ld,      2'd0);
    vecs[3]  = mkv(4'h0, 1'b0, 1'b1, 1'b0, o_ldwb,    2'd0);
    vecs[4]  = mkv(4'hD, 1'b0, 1'b1, 1'b0, o_fetch,   2'd1); // ALU op 5
    vecs[5]  = mkv(4'hD, 1'b0, 1'b1, 1'b0, o_none,    2'd1);
    vecs[6]  = mkv(4'hD, 1'b0, 1'b1, 1'b0, o_alu5,    2'd1);
    vecs[7]  = mkv(4'hD, 1'b0, 1'b1, 1'b0, o_awb5,    2'd1);
    vecs[8]  = mkv(4'h3, 1'b0, 1'b1, 1'b0, o_fetch,   2'd2); // BZ not taken
    vecs[9]  = mkv(4'h3, 1'b0, 1'b1, 1'b0, o_none,    2'd2);
    vecs[10] = mkv(4'h3, 1'b0, 1'b1, 1'b0, o_bz0,     2'd2);
    vecs[11] = mkv(4'h3, 1'b1, 1'b1, 1'b0, o_fetch,   2'd3); // BZ taken
    vecs[12] = mkv(4'h3, 1'b1, 1'b1, 1'b0, o_none,    2'd3);
    vecs[13] = mkv(4'h3, 1'b1, 1'b1, 1'b0, o_jump,    2'd3);
    vecs[14] = mkv(4'h2, 1'b0, 1'b1, 1'b0, o_fetch,   2'd0); // JMP, count wrapped
    vecs[15] = mkv(4'h2, 1'b0, 1'b1, 1'b0, o_none,    2'd0);
    vecs[16] = mkv(4'h2, 1'b0, 1'b1, 1'b0, o_jump,    2'd0);
    vecs[17] = mkv(4'h1, 1'b0, 1'b1, 1'b0, o_fetch,   2'd1); // ST with one wait
    vecs[18] = mkv(4'h1, 1'b0, 1'b1, 1'b0, o_none,    2'd1);
    vecs[19] = mkv(4'h1, 1'b0, 1'b0, 1'b0, o_st,      2'd1);
    vecs[20] = mkv(4'h1, 1'b0, 1'b1, 1'b0, o_st,      2'd1);
    vecs[21] = mkv(4'h7, 1'b0, 1'b1, 1'b1, o_fetch,   2'd2); // resume ignored
    vecs[22] = mkv(4'h7, 1'b0, 1'b1, 1'b1, o_none,    2'd2); // NOP retires
    vecs[23] = mkv(4'h0, 1'b0, 1'b0, 1'b0, o_wait_if, 2'd3);

    // Reset state: outputs forced low even with mem_ready high.
    drive(4'h0, 1'b0, 1'b1, 1'b0);
    #12;
    check_outs("reset_outs", o_none);
    check_cnt("reset_cnt", 2'd0);

    // Vector table.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].instr, vecs[i].zero, vecs[i].ready, vecs[i].resume);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].exp);
      check_cnt($sformatf("vec%0d_cnt", i), vecs[i].cnt);
      to_next();
    end

    // Watchdog: WAIT_MAX not-ready fetch cycles -> ERR, sticky.
    do_reset();
    for (int k = 0; k < WAIT_MAX; k++) begin
      drive(4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_outs($sformatf("wd_wait%0d", k), o_wait_if);
      to_next();
    end
    for (int k = 0; k < 3; k++) begin
      drive(4'h0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check_outs($sformatf("wd_err%0d", k), o_err);
      to_next();
    end

    // Watchdog: ready on the last allowed cycle is accepted.
    do_reset();
    for (int k = 0; k < WAIT_MAX - 1; k++) begin
      drive(4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_outs($sformatf("wd_late_wait%0d", k), o_wait_if);
      to_next();
    end
    drive(4'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_outs("wd_late_accept", o_fetch);
    to_next();
    @(negedge clk);
    check_outs("wd_late_dec", o_none);
    to_next();
    @(negedge clk);
    check_outs("wd_late_ld", o_ld);
    to_next();

    // HALT: count frozen, resume returns to IF without retiring.
    do_reset();
    drive(4'h5, 1'b0, 1'b1, 1'b0);
    to_next(); to_next();           // NOP retires -> count 1
    drive(4'h4, 1'b0, 1'b1, 1'b0);
    to_next(); to_next();           // fetch + decode HALT
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_outs($sformatf("halt%0d", k), o_halt);
      check_cnt($sformatf("halt%0d_cnt", k), 2'd1);
      to_next();
    end
    drive(4'h4, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_outs("halt_resume", o_halt);
    to_next();
    drive(4'h4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("halt_to_if", o_wait_if);
    check_cnt("halt_to_if_cnt", 2'd1);
    to_next();

    // Asynchronous reset in the middle of a store.
    do_reset();
    drive(4'h5, 1'b0, 1'b1, 1'b0);
    to_next(); to_next();           // NOP -> count 1
    drive(4'h1, 1'b0, 1'b1, 1'b0);
    to_next(); to_next();           // fetch + decode ST
    drive(4'h1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("st_before_rst", o_st);
    check_cnt("st_before_rst_cnt", 2'd1);
    #2 rst = 1'b0;
    #1;
    check_outs("st_async_rst", o_none);
    check_cnt("st_async_rst_cnt", 2'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("post_rst_if", o_wait_if);
    check_cnt("post_rst_cnt", 2'd0);
    to_next();

    // Counter wrap: five NOPs -> 1, 2, 3, 0, 1.
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      drive(4'h5, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check_outs($sformatf("nop%0d_fetch", n), o_fetch);
      check_cnt($sformatf("nop%0d_pre_cnt", n), 2'((n - 1) % 4));
      to_next();
      @(negedge clk);
      check_outs($sformatf("nop%0d_dec", n), o_none);
      to_next();
    end
    @(negedge clk);
    check_cnt("nop_final_cnt", 2'd1);
    to_next();

    // Randomised run against the reference model.
    do_reset();
    model_reset();
    cur_instr  = '0;
    err_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_err) begin
        err_cycles++;
        if (err_cycles > 3) begin
          do_reset();
          model_reset();
          err_cycles = 0;
        end
      end
      if (m_step == 0) cur_instr = 4'($urandom_range(0, 15));
      r   = ($urandom_range(0, 3) != 0);
      z   = 1'($urandom_range(0, 1));
      res = ($urandom_range(0, 3) == 0);
      drive(cur_instr, z, r, res);
      @(negedge clk);
      check_outs("rand_outs", model_out(r, z));
      check_cnt("rand_cnt", 2'(m_retired));
      model_step(cur_instr, r, res);
      to_next();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
